// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding for the bit-serial adder sequencer
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
endpackage

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: time-shares one external 1-bit full adder to add two WIDTH-bit
// operands LSB first, holding the ripple carry in a flop between bit slots.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_co,
   output logic             busy,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_ci,
   input  logic             fa_sum,
   input  logic             fa_co
);
   localparam int BW = $clog2(WIDTH);
   localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   sa_state_t        state;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q;
   logic [BW-1:0]    bit_idx, nxt_idx;
   logic [SW-1:0]    settle_cnt;
   logic             slot_end, last_bit;
   assign in_ready = rst_n && state == IDLE && !flush;
   assign nxt_idx  = bit_idx + 1'b1;
   assign slot_end = settle_cnt == SW'(SETTLE);
   assign last_bit = bit_idx == BW'(WIDTH - 1);
   assign out_sum  = sum_q;
   assign out_co   = carry_q;
   // Adder pins are registered one bit ahead so they change only on clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         bit_idx    <= '0;
         settle_cnt <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         fa_a       <= 1'b0;
         fa_b       <= 1'b0;
         fa_ci      <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         fa_a      <= 1'b0;
         fa_b      <= 1'b0;
         fa_ci     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               state      <= RUN;
               busy       <= 1'b1;
               a_q        <= in_a;
               b_q        <= in_b;
               carry_q    <= in_ci;
               bit_idx    <= '0;
               settle_cnt <= '0;
               fa_a       <= in_a[0];
               fa_b       <= in_b[0];
               fa_ci      <= in_ci;
            end
            RUN: if (!slot_end) settle_cnt <= settle_cnt + 1'b1;
            else begin
               sum_q[bit_idx] <= fa_sum;
               carry_q        <= fa_co;
               settle_cnt     <= '0;
               if (last_bit) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  fa_a      <= 1'b0;
                  fa_b      <= 1'b0;
                  fa_ci     <= 1'b0;
               end else begin
                  bit_idx <= nxt_idx;
                  fa_a    <= a_q[nxt_idx];
                  fa_b    <= b_q[nxt_idx];
                  fa_ci   <= fa_co;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at SETTLE=0 and SETTLE=2,
// each instance wired to its own behavioural 1-bit full adder.
module tb_serial_add_ctrl;
   typedef struct {
      logic [7:0] s;
      logic       c;
      int         lat;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic in_valid0 = 1'b0, in_valid2 = 1'b0, in_ci = 1'b0;
   logic [7:0] in_a = '0, in_b = '0;
   logic in_ready0, out_valid0, out_co0, busy0, fa_a0, fa_b0, fa_ci0, fa_sum0, fa_co0;
   logic in_ready2, out_valid2, out_co2, busy2, fa_a2, fa_b2, fa_ci2, fa_sum2, fa_co2;
   logic [7:0] out_sum0, out_sum2;
   exp_t q0[$], q2[$];
   int cyc = 0, cmp = 0, err = 0;
   int acc[2], rise[2];
   bit seen[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign {fa_co0, fa_sum0} = {1'b0, fa_a0} + {1'b0, fa_b0} + {1'b0, fa_ci0};
   assign {fa_co2, fa_sum2} = {1'b0, fa_a2} + {1'b0, fa_b2} + {1'b0, fa_ci2};

   serial_add_ctrl #(.WIDTH(8), .SETTLE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .out_valid(out_valid0), .out_ready(out_ready),
      .out_sum(out_sum0), .out_co(out_co0), .busy(busy0), .fa_a(fa_a0), .fa_b(fa_b0),
      .fa_ci(fa_ci0), .fa_sum(fa_sum0), .fa_co(fa_co0));

   serial_add_ctrl #(.WIDTH(8), .SETTLE(2)) u2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .out_valid(out_valid2), .out_ready(out_ready),
      .out_sum(out_sum2), .out_co(out_co2), .busy(busy2), .fa_a(fa_a2), .fa_b(fa_b2),
      .fa_ci(fa_ci2), .fa_sum(fa_sum2), .fa_co(fa_co2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      cmp++;
      if (act !== req) begin
         err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic mon(input int w, input logic v, input logic [7:0] s, input logic c);
      exp_t e;
      if (!v) seen[w] = 1'b0;
      else begin
         if (!seen[w]) begin
            seen[w] = 1'b1;
            rise[w] = cyc - acc[w];
         end
         if (out_ready && !flush) begin
            seen[w] = 1'b0;
            if ((w == 0) ? q0.size() == 0 : q2.size() == 0)
               chk(w == 0 ? "unexpected_result0" : "unexpected_result2", 32'd1, 32'd0);
            else begin
               e = (w == 0) ? q0.pop_front() : q2.pop_front();
               chk(w == 0 ? "sum0" : "sum2", {24'd0, s}, {24'd0, e.s});
               chk(w == 0 ? "co0" : "co2", {31'd0, c}, {31'd0, e.c});
               chk(w == 0 ? "latency0" : "latency2", rise[w], e.lat);
            end
         end
      end
   endtask

   // Monitor: samples 1 ns after the falling edge, once stimulus for the next rising edge is set.
   initial forever begin
      @(negedge clk);
      #1;
      if (in_valid0 && in_ready0) acc[0] = cyc + 1;
      if (in_valid2 && in_ready2) acc[1] = cyc + 1;
      mon(0, out_valid0, out_sum0, out_co0);
      mon(1, out_valid2, out_sum2, out_co2);
   end

   task automatic send(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (!(w == 0 ? in_ready0 : in_ready2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
      e.s = es; e.c = ec; e.lat = (w == 0) ? 8 : 24;
      if (w == 0) q0.push_back(e); else q2.push_back(e);
      in_a = a; in_b = b; in_ci = ci;
      if (w == 0) in_valid0 = 1'b1; else in_valid2 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0; in_valid2 = 1'b0;
   endtask

   task automatic wait_done(input int w);
      int n = 0;
      while (((w == 0) ? q0.size() : q2.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("result_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1);
   end

   initial begin
      int n;
      int seen_v;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid0}, 0);
      chk("rst_busy", {31'd0, busy0}, 0);
      chk("rst_fa", {29'd0, fa_a0, fa_b0, fa_ci0}, 0);
      chk("rst_out_sum", {24'd0, out_sum0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready0}, 1);
      chk("post_rst_in_ready2", {31'd0, in_ready2}, 1);
      send(0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
      wait_done(0);
      send(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      wait_done(0);
      send(0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
      wait_done(0);
      // Backpressure: result must hold while the sink stalls and new operands are ignored.
      out_ready = 1'b0;
      send(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
      n = 0;
      while (!out_valid0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("bp_valid_timeout", 32'd0, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid0 = 1'b1;
         in_a = 8'hC3;
         #1;
         chk("bp_out_valid", {31'd0, out_valid0}, 1);
         chk("bp_out_sum", {24'd0, out_sum0}, 32'h47);
         chk("bp_in_ready", {31'd0, in_ready0}, 0);
      end
      @(negedge clk);
      in_valid0 = 1'b0;
      out_ready = 1'b1;
      wait_done(0);
      // Flush during bit 3 with a live carry; the next operation must reload it.
      @(negedge clk);
      in_a = 8'hFF; in_b = 8'hFF; in_ci = 1'b1; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_busy", {31'd0, busy0}, 0);
      chk("flush_out_valid", {31'd0, out_valid0}, 0);
      chk("flush_fa", {29'd0, fa_a0, fa_b0, fa_ci0}, 0);
      seen_v = 0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (out_valid0) seen_v++;
      end
      chk("flush_no_result", seen_v, 0);
      send(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
      wait_done(0);
      // Asynchronous reset mid-operation must clear outputs before any clock edge.
      @(negedge clk);
      in_a = 8'hFF; in_b = 8'hFF; in_ci = 1'b1; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy0}, 0);
      chk("arst_out_valid", {31'd0, out_valid0}, 0);
      chk("arst_fa", {29'd0, fa_a0, fa_b0, fa_ci0}, 0);
      chk("arst_out_sum", {24'd0, out_sum0}, 0);
      chk("arst_out_co", {31'd0, out_co0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_in_ready", {31'd0, in_ready0}, 1);
      send(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      wait_done(1);
      send(1, 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
      wait_done(1);
      repeat (3) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
